aes_tlul_arb: RTL and testbench
===============================

// Module: aes_tlul_arb
// PURPOSE
//  Round-robin arbiter granting NumReq simple register requesters access to the single TL-UL device port of the aes core.
//  Exactly one transaction is outstanding at a time.
//  Builds the A-channel beat, waits for the D-channel response, and returns it to the granted requester.
//  A response timeout guarantees forward progress when the fuzzed DUT stalls.
//  Sits between the fuzz stimulus decoders and the aes DUT inside the fuzzing testbench.
// PARAMETERS
//  NumReq      2     number of requesters (2..8); requester index drives a_source
//  TimeoutCyc  1024  max cycles waiting for d_valid after A accept (>=2)
//  CntW        10    width of timeout counter; must satisfy 2**CntW >= TimeoutCyc
// PORTS
//  clk_i          in   1          clock
//  rst_i          in   1          synchronous reset, active high
//  req_valid_i    in   NumReq     requester k has a pending access
//  req_ready_o    out  NumReq     one-hot accept pulse to granted requester
//  req_we_i       in   NumReq     1=write, 0=read
//  req_addr_i     in   NumReq*32  byte address, requester k at [32k+:32]
//  req_wdata_i    in   NumReq*32  write data
//  req_mask_i     in   NumReq*4   byte enables
//  rsp_valid_o    out  NumReq     one-cycle response pulse to owning requester
//  rsp_rdata_o    out  32         read data (0 for writes/errors)
//  rsp_err_o      out  1          d_error, source mismatch, or timeout
//  tl_a_valid_o   out  1          A channel valid
//  tl_a_ready_i   in   1          A channel ready
//  tl_a_opcode_o  out  3          0 PutFull, 1 PutPartial, 4 Get
//  tl_a_address_o out  32         word-aligned address (addr[1:0] forced 0)
//  tl_a_data_o    out  32         write data
//  tl_a_mask_o    out  4          byte mask (4'hF for Get)
//  tl_a_source_o  out  8          granted index, zero-extended
//  tl_d_valid_i   in   1          D channel valid
//  tl_d_ready_o   out  1          D channel ready
//  tl_d_data_i    in   32         response data
//  tl_d_error_i   in   1          response error
//  tl_d_source_i  in   8          response source
//  busy_o         out  1          state != IDLE
//  stale_cnt_o    out  8          saturating count of dropped late/unmatched D beats
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, all valid/ready/rsp outputs 0, data outputs 0, stale_cnt_o=0. tl_d_ready_o=1 in IDLE.
//  FSM, one transaction at a time:
//   IDLE: if any req_valid_i, grant the first set index at or after rr pointer (wrapping);
//    pulse req_ready_o[g] the same cycle; latch we/addr/wdata/mask; ->ADDR.
//   ADDR: tl_a_valid_o=1 with fields held stable until tl_a_ready_i; on accept clear counter, ->RESP.
//    No timeout in ADDR.
//   RESP: tl_d_ready_o=1; counter increments each cycle.
//    On d_valid with d_source==g: capture data/err, ->DONE.
//    On d_valid with d_source!=g: capture with err=1, ->DONE.
//    On counter==TimeoutCyc-1 with no d_valid: err=1, rdata=0, ->DONE.
//    If d_valid and timeout coincide, d_valid wins.
//   DONE: rsp_valid_o[g]=1 for exactly one cycle; rr pointer=(g+1)%NumReq; ->IDLE.
//  Opcode: we=0 -> Get (4), mask=4'hF. we=1 and mask==4'hF -> PutFull (0). Otherwise PutPartial (1).
//  Write mask==0 is still issued as PutPartial.
//  rsp_rdata_o = d_data only for a Get without error, else 0.
//  Minimum latency req_ready->rsp_valid: 3 cycles (ADDR accept same cycle, d_valid next cycle).
//  d_valid seen in IDLE/ADDR/DONE: tl_d_ready_o=1 in IDLE only; beat dropped, stale_cnt_o++ (saturates at 255).
//  Requester must hold its request until req_ready_o; a deasserted request before grant is simply skipped.
//  rst_i mid-transaction aborts to IDLE with no response; a late D beat after reset counts as stale.
// TESTING
//  1. Single write req0 addr 0x04, data 0xDEADBEEF, mask F, a_ready=1, AccessAck next cycle
//     -> a_opcode=0, a_source=0, rsp_valid_o=01 after 3 cycles, err=0, rdata=0.
//  2. req0+req1 both valid continuously, 4 reads -> grant order 0,1,0,1; a_source matches; rdata = d_data per beat.
//  3. Read, DUT never responds, TimeoutCyc=16 -> rsp_err_o=1 on cycle 18 after grant, rdata=0;
//     then a late d_valid -> stale_cnt_o=1.
//  4. Response with d_source=5 for grant 1 -> rsp_valid_o[1]=1, rsp_err_o=1.
//  5. Write mask 4'b0011 with a_ready low 5 cycles -> a_opcode=1; a_* fields stable throughout; single accept.
//  6. rst_i asserted in RESP -> next cycle busy_o=0, all outputs at reset values, no rsp_valid_o pulse.

Source files
------------

// File: rtl/aes_tlul_arb.sv
// Round-robin arbiter that multiplexes NumReq register requesters onto the single
// TL-UL device port of the aes core, one outstanding transaction at a time.
module aes_tlul_arb #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned TimeoutCyc = 1024,
    parameter int unsigned CntW       = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq-1:0]      req_we_i,
    input  logic [NumReq*32-1:0]   req_addr_i,
    input  logic [NumReq*32-1:0]   req_wdata_i,
    input  logic [NumReq*4-1:0]    req_mask_i,
    output logic [NumReq-1:0]      rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   tl_a_valid_o,
    input  logic                   tl_a_ready_i,
    output logic [2:0]             tl_a_opcode_o,
    output logic [31:0]            tl_a_address_o,
    output logic [31:0]            tl_a_data_o,
    output logic [3:0]             tl_a_mask_o,
    output logic [7:0]             tl_a_source_o,
    input  logic                   tl_d_valid_i,
    output logic                   tl_d_ready_o,
    input  logic [31:0]            tl_d_data_i,
    input  logic                   tl_d_error_i,
    input  logic [7:0]             tl_d_source_i,
    output logic                   busy_o,
    output logic [7:0]             stale_cnt_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, gnt_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [3:0]        mask_q;
    logic              err_q;
    logic [7:0]        stale_q;

    logic              found;
    logic [IdxW-1:0]   pick;
    logic              sel_we;
    logic [31:0]       sel_addr, sel_wdata;
    logic [3:0]        sel_mask;
    logic [2:0]        sel_op;
    logic              timeout, src_match;
    int unsigned       k;

    // Scan from the round-robin pointer, wrapping, and take the first live request.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_mask  = '0;
        k         = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = (32'(rr_q) + i) % NumReq;
            if (!found && req_valid_i[k]) begin
                found     = 1'b1;
                pick      = IdxW'(k);
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[32*k +: 32];
                sel_wdata = req_wdata_i[32*k +: 32];
                sel_mask  = req_mask_i[4*k +: 4];
            end
        end
        if (!sel_we)                sel_op = OpGet;
        else if (sel_mask == 4'hF)  sel_op = OpPutFull;
        else                        sel_op = OpPutPartial;
    end

    assign timeout   = (cnt_q == CntW'(TimeoutCyc - 1));
    assign src_match = (tl_d_source_i == 8'(gnt_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = '0;
        tl_a_valid_o = 1'b0;
        tl_d_ready_o = 1'b0;
        rsp_valid_o  = '0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                tl_d_ready_o = 1'b1;
                if (found) begin
                    req_ready_o = NumReq'(1) << pick;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                tl_a_valid_o = 1'b1;
                if (tl_a_ready_i) state_d = RESP;
            end
            RESP: begin
                tl_d_ready_o = 1'b1;
                if (tl_d_valid_i || timeout) state_d = DONE;
            end
            DONE: begin
                rsp_valid_o = NumReq'(1) << gnt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            stale_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_q   <= pick;
                        op_q    <= sel_op;
                        addr_q  <= {sel_addr[31:2], 2'b00};
                        wdata_q <= sel_wdata;
                        mask_q  <= sel_we ? sel_mask : 4'hF;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ADDR: if (tl_a_ready_i) cnt_q <= '0;
                RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A beat arriving on the timeout cycle still counts as the response.
                    if (tl_d_valid_i) begin
                        err_q   <= tl_d_error_i | ~src_match;
                        rdata_q <= (op_q == OpGet && !tl_d_error_i && src_match) ? tl_d_data_i : '0;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                DONE: rr_q <= (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
                default: ;
            endcase
            if (tl_d_valid_i && state_q != RESP && stale_q != 8'hFF)
                stale_q <= stale_q + 8'd1;
        end
    end

    assign tl_a_opcode_o  = op_q;
    assign tl_a_address_o = addr_q;
    assign tl_a_data_o    = wdata_q;
    assign tl_a_mask_o    = mask_q;
    assign tl_a_source_o  = 8'(gnt_q);
    assign rsp_rdata_o    = (state_q == DONE) ? rdata_q : '0;
    assign rsp_err_o      = (state_q == DONE) ? err_q : 1'b0;
    assign stale_cnt_o    = stale_q;

endmodule

// File: tb/tb_aes_tlul_arb.sv
// Directed bench for aes_tlul_arb: NumReq=2, TimeoutCyc=16, hand-computed expectations.
module tb_aes_tlul_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_mask;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic [7:0]  a_source;
    logic        d_valid, d_ready, d_error;
    logic [31:0] d_data;
    logic [7:0]  d_source;
    logic        busy;
    logic [7:0]  stale_cnt;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    aes_tlul_arb #(.NumReq(2), .TimeoutCyc(16), .CntW(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_mask_i(req_mask),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .tl_a_valid_o(a_valid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(a_opcode),
        .tl_a_address_o(a_address), .tl_a_data_o(a_data), .tl_a_mask_o(a_mask),
        .tl_a_source_o(a_source), .tl_d_valid_i(d_valid), .tl_d_ready_o(d_ready),
        .tl_d_data_i(d_data), .tl_d_error_i(d_error), .tl_d_source_i(d_source),
        .busy_o(busy), .stale_cnt_o(stale_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    // Read by requester g with both requesters kept valid; response arrives the cycle after accept.
    task automatic rd_txn(input int unsigned g, input logic [31:0] exp_addr, input logic [31:0] dd);
        #2;
        check("t2_grant", 32'(req_ready), 32'(1 << g));
        nxt(); a_ready = 1'b1; #2;
        check("t2_a_valid", 32'(a_valid), 32'd1);
        check("t2_opcode", 32'(a_opcode), 32'd4);
        check("t2_mask", 32'(a_mask), 32'hF);
        check("t2_source", 32'(a_source), g);
        check("t2_addr", a_address, exp_addr);
        nxt(); d_valid = 1'b1; d_source = 8'(g); d_data = dd; #2;
        check("t2_d_ready", 32'(d_ready), 32'd1);
        nxt(); d_valid = 1'b0; #2;
        check("t2_rsp_valid", 32'(rsp_valid), 32'(1 << g));
        check("t2_rdata", rsp_rdata, dd);
        check("t2_err", 32'(rsp_err), 32'd0);
        nxt();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
        a_ready = 1'b0; d_valid = 1'b0; d_error = 1'b0; d_data = '0; d_source = '0;
        nxt(); nxt(); #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_stale", 32'(stale_cnt), 32'd0);
        check("rst_a_addr", a_address, 32'd0);
        rst = 1'b0;

        // Test 1: full-mask write from requester 0
        nxt();
        req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'h4;
        req_wdata[31:0] = 32'hDEADBEEF; req_mask[3:0] = 4'hF; a_ready = 1'b1; #2;
        check("t1_grant", 32'(req_ready), 32'h1);
        nxt(); req_valid = '0; #2;
        check("t1_a_valid", 32'(a_valid), 32'd1);
        check("t1_opcode", 32'(a_opcode), 32'd0);
        check("t1_source", 32'(a_source), 32'd0);
        check("t1_addr", a_address, 32'h4);
        check("t1_data", a_data, 32'hDEADBEEF);
        nxt(); d_valid = 1'b1; d_source = 8'd0; d_data = 32'h12345678; #2;
        check("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        nxt(); d_valid = 1'b0; #2;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_err", 32'(rsp_err), 32'd0);
        check("t1_rdata", rsp_rdata, 32'd0);
        nxt(); #2;
        check("t1_rsp_once", 32'(rsp_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Test 2: both requesters reading continuously from a fresh pointer
        do_reset();
        req_valid = 2'b11; req_we = 2'b00; a_ready = 1'b0;
        req_addr = {32'h0000020B, 32'h00000107};
        rd_txn(0, 32'h104, 32'hA0A0_0001);
        rd_txn(1, 32'h208, 32'hB1B1_0002);
        rd_txn(0, 32'h104, 32'hC2C2_0003);
        rd_txn(1, 32'h208, 32'hD3D3_0004);
        req_valid = '0;

        // Test 3: read never answered -> timeout on cycle 18 after grant, then a late beat
        nxt();
        req_valid = 2'b01; req_we = 2'b00; a_ready = 1'b1; d_data = 32'hFFFF_FFFF; #2;
        check("t3_grant", 32'(req_ready), 32'h1);
        nxt(); req_valid = '0;
        for (int c = 2; c <= 17; c++) begin
            nxt(); #2;
            check("t3_wait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        nxt(); #2;
        check("t3_timeout_rsp", 32'(rsp_valid), 32'h1);
        check("t3_timeout_err", 32'(rsp_err), 32'd1);
        check("t3_timeout_rdata", rsp_rdata, 32'd0);
        nxt(); d_valid = 1'b1; d_source = 8'd0; #2;
        check("t3_idle", 32'(busy), 32'd0);
        nxt(); d_valid = 1'b0; #2;
        check("t3_stale", 32'(stale_cnt), 32'd1);

        // Test 4: source mismatch on a grant to requester 1
        nxt();
        req_valid = 2'b10; req_we = 2'b00; #2;
        check("t4_grant", 32'(req_ready), 32'h2);
        nxt(); req_valid = '0; #2;
        check("t4_source", 32'(a_source), 32'd1);
        nxt(); d_valid = 1'b1; d_source = 8'd5; d_data = 32'hAAAA5555; d_error = 1'b0;
        nxt(); d_valid = 1'b0; #2;
        check("t4_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t4_err", 32'(rsp_err), 32'd1);
        check("t4_rdata", rsp_rdata, 32'd0);

        // Test 5: partial write held off by a_ready for 5 cycles
        nxt();
        req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'h30;
        req_wdata[31:0] = 32'h0000BEEF; req_mask[3:0] = 4'b0011; a_ready = 1'b0; #2;
        check("t5_grant", 32'(req_ready), 32'h1);
        nxt(); req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) a_ready = 1'b1;
            #2;
            check("t5_a_valid", 32'(a_valid), 32'd1);
            check("t5_opcode", 32'(a_opcode), 32'd1);
            check("t5_addr", a_address, 32'h30);
            check("t5_data", a_data, 32'h0000BEEF);
            check("t5_mask", 32'(a_mask), 32'h3);
            nxt();
        end
        d_valid = 1'b1; d_source = 8'd0; d_error = 1'b1; #2;
        check("t5_single_accept", 32'(a_valid), 32'd0);
        nxt(); d_valid = 1'b0; d_error = 1'b0; #2;
        check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t5_err", 32'(rsp_err), 32'd1);
        check("t5_stale_kept", 32'(stale_cnt), 32'd1);

        // Test 6: reset while waiting for the response
        nxt();
        req_valid = 2'b10; req_we = 2'b00; a_ready = 1'b1; #2;
        check("t6_grant", 32'(req_ready), 32'h2);
        nxt(); req_valid = '0;
        nxt(); rst = 1'b1; #2;
        check("t6_in_resp", 32'(busy), 32'd1);
        nxt(); rst = 1'b0; #2;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_a_valid", 32'(a_valid), 32'd0);
        check("t6_d_ready", 32'(d_ready), 32'd1);
        check("t6_stale", 32'(stale_cnt), 32'd0);
        check("t6_opcode", 32'(a_opcode), 32'd0);
        check("t6_source", 32'(a_source), 32'd0);
        check("t6_rsp_err", 32'(rsp_err), 32'd0);
        d_valid = 1'b1; d_source = 8'd1;
        nxt(); d_valid = 1'b0; #2;
        check("t6_late_stale", 32'(stale_cnt), 32'd1);
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
